// File: rtl/mania_pkg.sv
// -----------------------------------------------------------------------------
// mania_pkg
// Shared constants and helpers for the 4-key mania screen pipeline.
//   NUM_LANES            : number of playfield lanes
//   H_VISIBLE/V_VISIBLE  : visible raster size from vgac
//   COL_*                : 12-bit RGB colour words fed to vgac
//   LFSR_TAPS            : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next/popcount4/sat_add16 : small combinational helpers
// -----------------------------------------------------------------------------
package mania_pkg;

    localparam int NUM_LANES = 4;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam logic [11:0] COL_BG         = 12'h000;
    localparam logic [11:0] COL_NOTE       = 12'hFFF;
    localparam logic [11:0] COL_JUDGE      = 12'h333;
    localparam logic [11:0] COL_JUDGE_HELD = 12'h0F0;
    localparam logic [11:0] COL_BORDER     = 12'h888;
    localparam logic [11:0] COL_LANE       = 12'h111;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift-left Fibonacci step: parity of the tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/note_field_render_if.sv
// -----------------------------------------------------------------------------
// note_field_render_if
// Pixel bus between vgac and its pixel source.
//   row_addr : current row (0..479 visible)
//   col_addr : current column (0..639 visible)
//   rdn      : 0 = visible pixel
//   d_in     : 12-bit colour word returned to vgac
// master = vgac side, slave = pixel source side.
// -----------------------------------------------------------------------------
interface note_field_render_if;

    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_in;

    modport master (output row_addr, output col_addr, output rdn, input d_in);
    modport slave  (input row_addr, input col_addr, input rdn, output d_in);

endinterface

// File: rtl/key_sync_edge.sv
// -----------------------------------------------------------------------------
// key_sync_edge
// Two-flop synchroniser per bit followed by a rising-edge detector.
//   clk       : sampling clock
//   rst_n     : asynchronous active-low reset
//   key_raw   : asynchronous active-high inputs
//   key_held  : synchronised level
//   key_press : one-cycle pulse on each synchronised rising edge
// A pin change shows up on key_press two clocks later.
// -----------------------------------------------------------------------------
module key_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_held,
    output logic [WIDTH-1:0] key_press
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // NOTE: non-blocking assignments keep the flop chain a true pipeline;
    // blocking ones would let key_raw race through all stages in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign key_held  = sync2_q;
    assign key_press = sync2_q & ~prev_q;

endmodule

// File: rtl/note_field_render.sv
// -----------------------------------------------------------------------------
// note_field_render
// Pixel source for vgac: scrolling 4-lane note field with LFSR note spawning,
// key synchronisation, hit/miss judging at the bottom cell and score counters.
//   vga_clk    : pixel clock
//   clrn       : asynchronous active-low reset
//   run        : 1 = scroll/spawn/judge advance, 0 = freeze (render continues)
//   key[3:0]   : raw asynchronous lane keys
//   vga        : row/col/rdn in, d_in out (registered, 1-cycle latency)
//   hit_count  : saturating hit counter
//   miss_count : saturating miss counter
// -----------------------------------------------------------------------------
module note_field_render
    import mania_pkg::*;
#(
    parameter int          LANE_X0       = 192,
    parameter int          LANE_W        = 64,
    parameter int          CELL_H        = 16,
    parameter int          CELLS         = 30,
    parameter int          SCROLL_FRAMES = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                vga_clk,
    input  logic                clrn,
    input  logic                run,
    input  logic [3:0]          key,
    note_field_render_if.slave  vga,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    localparam int FC_W       = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int CELL_SHIFT = $clog2(CELL_H);
    localparam int CELL_IDX_W = $clog2(CELLS);
    localparam int LANE_IDX_W = $clog2(NUM_LANES);
    localparam int JUDGE_CELL = CELLS - 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_FRAMES - 1);

    // Bit c of a lane is cell c counted from the top; bit CELLS-1 is the judge cell.
    logic [NUM_LANES-1:0][CELLS-1:0] field_q, field_d;
    logic [7:0]                      lfsr_q, lfsr_d;
    logic [FC_W-1:0]                 frame_cnt_q, frame_cnt_d;
    logic [15:0]                     hit_count_q, hit_count_d;
    logic [15:0]                     miss_count_q, miss_count_d;
    logic [11:0]                     d_in_q, d_in_d;

    logic [NUM_LANES-1:0] key_held, key_press;
    logic [NUM_LANES-1:0] press_live, judge_note, hit_vec, miss_vec, spawn;
    logic                 frame_tick, step;

    key_sync_edge #(.WIDTH(NUM_LANES)) u_key_sync_edge (
        .clk       (vga_clk),
        .rst_n     (clrn),
        .key_raw   (key),
        .key_held  (key_held),
        .key_press (key_press)
    );

    // Last visible pixel: the field then changes during vblank, so no tearing.
    assign frame_tick = !vga.rdn
                        && (vga.row_addr == 9'(V_VISIBLE - 1))
                        && (vga.col_addr == 10'(H_VISIBLE - 1));
    assign step = run && frame_tick && (frame_cnt_q == FC_LAST);

    // Game state: frame counter, judging, field shift, LFSR, score counters.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        field_d     = field_q;
        lfsr_d      = lfsr_q;

        if (run && frame_tick) begin
            frame_cnt_d = step ? '0 : frame_cnt_q + 1'b1;
        end

        press_live = run ? key_press : '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            judge_note[i] = field_q[i][JUDGE_CELL];
            spawn[i]      = lfsr_q[i] & lfsr_q[i+4];
        end

        // Presses are judged against pre-shift content; a hit beats fall-off.
        hit_vec  = press_live & judge_note;
        miss_vec = (press_live & ~judge_note)
                 | ({NUM_LANES{step}} & judge_note & ~press_live);

        for (int i = 0; i < NUM_LANES; i++) begin
            if (step) begin
                field_d[i] = {field_q[i][CELLS-2:0], spawn[i]};
            end else if (hit_vec[i]) begin
                field_d[i][JUDGE_CELL] = 1'b0;
            end
        end

        if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end

        hit_count_d  = sat_add16(hit_count_q,  popcount4(hit_vec));
        miss_count_d = sat_add16(miss_count_q, popcount4(miss_vec));
    end

    // Render: locate lane and cell for the current pixel, then apply priority
    // rdn > outside > note > judge > border > empty lane.
    logic [8:0]            row_cell;
    logic [CELL_IDX_W-1:0] cell_idx;
    logic [LANE_IDX_W-1:0] lane_sel;
    logic                  cell_valid, in_lane, on_border, note_here, judge_here;
    int                    col_i;

    always_comb begin
        col_i     = int'(vga.col_addr);
        in_lane   = 1'b0;
        on_border = 1'b0;
        lane_sel  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (col_i >= LANE_X0 + i * LANE_W && col_i < LANE_X0 + (i + 1) * LANE_W) begin
                in_lane   = 1'b1;
                lane_sel  = LANE_IDX_W'(i);
                on_border = (col_i == LANE_X0 + i * LANE_W);
            end
        end

        row_cell   = vga.row_addr >> CELL_SHIFT;
        cell_valid = (row_cell < 9'(CELLS));
        cell_idx   = CELL_IDX_W'(row_cell);
        note_here  = in_lane && cell_valid && field_q[lane_sel][cell_idx];
        judge_here = in_lane && cell_valid && (cell_idx == CELL_IDX_W'(JUDGE_CELL));

        d_in_d = COL_LANE;
        if (vga.rdn || !in_lane) begin
            d_in_d = COL_BG;
        end else if (note_here) begin
            d_in_d = COL_NOTE;
        end else if (judge_here) begin
            d_in_d = key_held[lane_sel] ? COL_JUDGE_HELD : COL_JUDGE;
        end else if (on_border) begin
            d_in_d = COL_BORDER;
        end
    end

    // NOTE: the field is a small flop array rather than a RAM, so it is cleared
    // by reset along with everything else; a RAM-backed field could not be.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            field_q      <= '0;
            lfsr_q       <= LFSR_SEED;
            frame_cnt_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            d_in_q       <= COL_BG;
        end else begin
            field_q      <= field_d;
            lfsr_q       <= lfsr_d;
            frame_cnt_q  <= frame_cnt_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            d_in_q       <= d_in_d;
        end
    end

    assign vga.d_in   = d_in_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_note_field_render.sv
// -----------------------------------------------------------------------------
// tb_note_field_render
// Directed bench for note_field_render. Raster inputs are driven directly so a
// frame tick costs one cycle. A small reference model (field, LFSR, counters)
// tracks what the DUT should hold; early values are also hand-derived.
// -----------------------------------------------------------------------------
module tb_note_field_render;
    import mania_pkg::*;

    localparam int CELLS = 30;
    localparam int SF    = 4;
    localparam int JUDGE = CELLS - 1;

    logic        vga_clk = 1'b0;
    logic        clrn    = 1'b0;
    logic        run     = 1'b0;
    logic [3:0]  key     = 4'b0000;
    logic [15:0] hit_count, miss_count;

    note_field_render_if vga_if ();

    note_field_render dut (
        .vga_clk    (vga_clk),
        .clrn       (clrn),
        .run        (run),
        .key        (key),
        .vga        (vga_if),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #20 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [CELLS-1:0] m_field [4];
    logic [7:0]       m_lfsr;
    int               m_fc;
    logic [15:0]      m_hits, m_miss;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] m_judge();
        logic [3:0] j;
        for (int i = 0; i < 4; i++) j[i] = m_field[i][JUDGE];
        return j;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_field[i] = '0;
        m_lfsr = 8'hA5;
        m_fc   = 0;
        m_hits = '0;
        m_miss = '0;
    endtask

    task automatic m_press(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (m_field[i][JUDGE]) begin
                    m_hits = sat_inc(m_hits);
                    m_field[i][JUDGE] = 1'b0;
                end else begin
                    m_miss = sat_inc(m_miss);
                end
            end
        end
    endtask

    task automatic m_step(input logic [3:0] press);
        logic fb;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin
                if (m_field[i][JUDGE]) m_hits = sat_inc(m_hits);
                else                   m_miss = sat_inc(m_miss);
            end else if (m_field[i][JUDGE]) begin
                m_miss = sat_inc(m_miss);
            end
        end
        for (int i = 0; i < 4; i++)
            m_field[i] = {m_field[i][CELLS-2:0], m_lfsr[i] & m_lfsr[i+4]};
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    task automatic set_raster(input logic [8:0] r, input logic [9:0] c, input logic rd);
        vga_if.row_addr = r;
        vga_if.col_addr = c;
        vga_if.rdn      = rd;
    endtask

    task automatic frame_tick();
        @(negedge vga_clk) set_raster(9'd479, 10'd639, 1'b0);
        @(negedge vga_clk) set_raster(9'd0, 10'd0, 1'b1);
        if (run) begin
            if (m_fc == SF - 1) begin
                m_step(4'b0000);
                m_fc = 0;
            end else begin
                m_fc++;
            end
        end
    endtask

    task automatic probe(input logic [8:0] r, input logic [9:0] c, input logic rd,
                         output logic [11:0] pix);
        @(negedge vga_clk) set_raster(r, c, rd);
        @(negedge vga_clk) pix = vga_if.d_in;
        set_raster(9'd0, 10'd0, 1'b1);
    endtask

    task automatic press_lanes(input logic [3:0] mask);
        @(negedge vga_clk) key = key | mask;
        @(negedge vga_clk);
        @(negedge vga_clk) key = key & ~mask;
        @(negedge vga_clk);
        @(negedge vga_clk);
        if (run) m_press(mask);
    endtask

    // Advance whole scroll steps until the model's judge row matches.
    task automatic step_until(input logic [3:0] want_set, input logic [3:0] want_clr);
        bit found = 0;
        for (int s = 0; s < 600 && !found; s++) begin
            if ((m_judge() & want_set) == want_set && (m_judge() & want_clr) == 4'b0000)
                found = 1;
            else
                do frame_tick(); while (m_fc != 0);
        end
        check("step_until_reached", 32'(found), 32'd1);
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_hits"}, 32'(hit_count), 32'(m_hits));
        check({tag, "_miss"}, 32'(miss_count), 32'(m_miss));
        check({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'(m_lfsr));
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_field%0d", tag, i), 32'(dut.field_q[i]), 32'(m_field[i]));
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pix;
        logic [15:0] h0, mi0, exp_h, exp_m;

        set_raster(9'd0, 10'd0, 1'b1);
        m_reset();
        repeat (2) @(negedge vga_clk);
        check("rst_d_in", 32'(vga_if.d_in), 32'h000);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);

        @(negedge vga_clk) begin clrn = 1'b1; run = 1'b1; end

        // 16 ticks = 4 steps from seed A5: spawns 0000,0000,0001,0010; lfsr 54.
        repeat (4 * SF) frame_tick();
        check("t1_lfsr",   32'(dut.lfsr_q),     32'h54);
        check("t1_lane0",  32'(dut.field_q[0]), 32'h2);
        check("t1_lane1",  32'(dut.field_q[1]), 32'h1);
        check("t1_lane2",  32'(dut.field_q[2]), 32'h0);
        check("t1_lane3",  32'(dut.field_q[3]), 32'h0);
        probe(9'd20,  10'd200, 1'b0, pix); check("pix_note_l0c1", 32'(pix), 32'hFFF);
        probe(9'd5,   10'd260, 1'b0, pix); check("pix_note_l1c0", 32'(pix), 32'hFFF);
        probe(9'd5,   10'd330, 1'b0, pix); check("pix_empty_l2",  32'(pix), 32'h111);
        probe(9'd100, 10'd192, 1'b0, pix); check("pix_border_l0", 32'(pix), 32'h888);
        probe(9'd20,  10'd100, 1'b0, pix); check("pix_outside",   32'(pix), 32'h000);
        probe(9'd20,  10'd200, 1'b1, pix); check("pix_blank",     32'(pix), 32'h000);
        probe(9'd470, 10'd400, 1'b0, pix); check("pix_judge_l3",  32'(pix), 32'h333);

        // Hit in lane 2 with pipeline latency.
        step_until(4'b0100, 4'b0000);
        h0 = m_hits; mi0 = m_miss;
        @(negedge vga_clk) key[2] = 1'b1;
        @(negedge vga_clk);
        @(negedge vga_clk) begin
            check("hit_not_early", 32'(hit_count), 32'(h0));
            key[2] = 1'b0;
        end
        @(negedge vga_clk);
        m_press(4'b0100);
        check("hit_after_3", 32'(hit_count), 32'(sat_inc(h0)));
        check("hit_clears_judge", 32'(dut.field_q[2][JUDGE]), 32'd0);
        check("hit_no_miss", 32'(miss_count), 32'(mi0));

        // Miss on empty judge cell in lane 1, then held-key colour.
        step_until(4'b0000, 4'b0010);
        mi0 = m_miss;
        press_lanes(4'b0010);
        check("empty_press_miss", 32'(miss_count), 32'(mi0 + 16'd1));
        @(negedge vga_clk) key[1] = 1'b1;
        repeat (3) @(negedge vga_clk);
        m_press(4'b0010);
        probe(9'd470, 10'd260, 1'b0, pix);
        check("pix_judge_held", 32'(pix), 32'h0F0);
        @(negedge vga_clk) key[1] = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("held_miss_count", 32'(miss_count), 32'(m_miss));

        // Two simultaneous fall-off misses (lanes 0 and 3 only).
        step_until(4'b1001, 4'b0110);
        mi0 = m_miss;
        repeat (SF - 1) frame_tick();
        check("falloff_not_early", 32'(miss_count), 32'(mi0));
        @(negedge vga_clk) set_raster(9'd479, 10'd639, 1'b0);
        @(negedge vga_clk) begin
            check("falloff_pair", 32'(miss_count), 32'(mi0 + 16'd2));
            set_raster(9'd0, 10'd0, 1'b1);
        end
        m_step(4'b0000); m_fc = 0;

        // Press in lane 0 on the exact step cycle.
        step_until(4'b0001, 4'b0000);
        repeat (SF - 1) frame_tick();
        exp_h = sat_inc(m_hits);
        exp_m = m_miss + 16'(popcount4(m_judge() & 4'b1110));
        @(negedge vga_clk) key[0] = 1'b1;
        @(negedge vga_clk);
        @(negedge vga_clk) begin set_raster(9'd479, 10'd639, 1'b0); key[0] = 1'b0; end
        @(negedge vga_clk) begin
            check("step_press_hit",  32'(hit_count),  32'(exp_h));
            check("step_press_miss", 32'(miss_count), 32'(exp_m));
            set_raster(9'd0, 10'd0, 1'b1);
        end
        m_step(4'b0001); m_fc = 0;
        compare_state("after_step_press");

        // Saturation: preload near the top, then two more hits.
        @(negedge vga_clk) force dut.hit_count_q = 16'hFFFE;
        @(negedge vga_clk) release dut.hit_count_q;
        m_hits = 16'hFFFE;
        @(negedge vga_clk);
        check("sat_preload", 32'(hit_count), 32'hFFFE);
        step_until(4'b0001, 4'b0000);
        press_lanes(4'b0001);
        check("sat_hit1", 32'(hit_count), 32'hFFFF);
        step_until(4'b0001, 4'b0000);
        press_lanes(4'b0001);
        check("sat_hit2_hold", 32'(hit_count), 32'hFFFF);

        // Freeze: ticks and presses must change nothing.
        @(negedge vga_clk) run = 1'b0;
        repeat (22) frame_tick();
        press_lanes(4'b1111);
        compare_state("frozen");
        @(negedge vga_clk) run = 1'b1;
        do frame_tick(); while (m_fc != 0);
        compare_state("resumed");

        // Asynchronous reset in the middle of row 200.
        @(negedge vga_clk) set_raster(9'd200, 10'd200, 1'b0);
        @(negedge vga_clk);
        check("pre_reset_pix", 32'(vga_if.d_in), m_field[0][12] ? 32'hFFF : 32'h111);
        #5 clrn = 1'b0;
        #1;
        check("async_rst_d_in", 32'(vga_if.d_in), 32'h000);
        check("async_rst_hits", 32'(hit_count), 32'd0);
        check("async_rst_miss", 32'(miss_count), 32'd0);
        check("async_rst_lfsr", 32'(dut.lfsr_q), 32'hA5);
        check("async_rst_field", 32'(dut.field_q), 32'd0);
        @(negedge vga_clk) begin clrn = 1'b1; set_raster(9'd0, 10'd0, 1'b1); end
        m_reset();
        repeat (SF - 1) frame_tick();
        check("post_rst_no_step", 32'(dut.lfsr_q), 32'hA5);
        frame_tick();
        check("post_rst_step_lfsr", 32'(dut.lfsr_q), 32'h4A);
        compare_state("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
